// File: rtl/r88_pkg.sv
// Shared definitions for the Rocket88 memory bus controller.
package r88_pkg;

  // Bus cycle phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } busState_e;

  localparam int unsigned WAIT_MIN_DEF = 1;
  localparam int unsigned TIMEOUT_DEF  = 255;
  localparam int unsigned WAIT_W       = 8;
  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned BYTE_W       = 8;

endpackage

// File: rtl/r88_busctl.sv
// Rocket88 memory bus controller: byte / little-endian 16-bit external bus
// cycles with ready-driven wait states and a per-byte strobe timeout.
module r88_busctl
  import r88_pkg::*;
#(
  parameter int unsigned WAIT_MIN = WAIT_MIN_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                sysClock,
  input  logic                sysResetN,
  input  logic [ADDR_W-1:0]   regAddr,
  input  logic [2*BYTE_W-1:0] memWData,
  input  logic                memRead,
  input  logic                memWrite,
  input  logic                memWord,
  input  logic                busRead,
  inout  wire  [BYTE_W-1:0]   intD,
  output logic [BYTE_W-1:0]   highOut,
  output logic                memBusy,
  output logic                memDone,
  output logic                memErr,
  output logic [ADDR_W-1:0]   extA,
  inout  wire  [BYTE_W-1:0]   extD,
  output logic                extRdN,
  output logic                extWrN,
  input  logic                extReady
);

  localparam logic [WAIT_W-1:0] waitMinC = WAIT_W'(WAIT_MIN);
  localparam logic [WAIT_W-1:0] timeoutC = WAIT_W'(TIMEOUT);

  busState_e             state;
  logic [WAIT_W-1:0]     waitCnt;
  logic                  rdOp;
  logic                  wordOp;
  logic                  secondByte;
  logic [2*BYTE_W-1:0]   wData;
  logic [BYTE_W-1:0]     lowData;

  // Bus sequencer; memErr doubles as the "access aborted" marker inside HOLD
  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      state      <= IDLE;
      waitCnt    <= '0;
      rdOp       <= 1'b0;
      wordOp     <= 1'b0;
      secondByte <= 1'b0;
      wData      <= '0;
      lowData    <= '0;
      highOut    <= '0;
      memBusy    <= 1'b0;
      memDone    <= 1'b0;
      memErr     <= 1'b0;
      extA       <= '0;
      extRdN     <= 1'b1;
      extWrN     <= 1'b1;
    end else begin
      memDone <= 1'b0;
      case (state)
        IDLE: begin
          if (memRead || memWrite) begin
            extA       <= regAddr;
            rdOp       <= memRead;
            wordOp     <= memWord;
            wData      <= memWData;
            secondByte <= 1'b0;
            memErr     <= 1'b0;
            memBusy    <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          waitCnt <= WAIT_W'(1);
          if (rdOp) extRdN <= 1'b0;
          else      extWrN <= 1'b0;
          state <= STROBE;
        end
        STROBE: begin
          if (waitCnt >= waitMinC && extReady) begin
            extRdN <= 1'b1;
            extWrN <= 1'b1;
            if (rdOp) begin
              if (secondByte) highOut <= extD;
              else            lowData <= extD;
            end
            if (!wordOp || secondByte) memDone <= 1'b1;
            state <= HOLD;
          end else if (waitCnt >= timeoutC) begin
            extRdN  <= 1'b1;
            extWrN  <= 1'b1;
            memErr  <= 1'b1;
            memDone <= 1'b1;
            state   <= HOLD;
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end
        HOLD: begin
          if (wordOp && !secondByte && !memErr) begin
            secondByte <= 1'b1;
            extA       <= extA + ADDR_W'(1);
            state      <= SETUP;
          end else begin
            memBusy <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tri-state drivers; follow reset asynchronously via state/rdOp
  assign intD = busRead ? lowData : {BYTE_W{1'bz}};
  assign extD = (!rdOp && state != IDLE)
              ? (secondByte ? wData[2*BYTE_W-1:BYTE_W] : wData[BYTE_W-1:0])
              : {BYTE_W{1'bz}};

endmodule

// File: doc/r88_busctl.md
# r88_busctl

Memory bus controller for the Rocket88 core. It sits directly downstream of `r88_regblock`: it takes the register-selected address (`regAddr`) and runs byte or 16-bit little-endian read/write cycles on the external bus, with ready-driven wait states and a timeout. Read data goes back onto the internal data bus `intD`. For 16-bit reads the high byte is returned on `highOut`, which feeds the register block's 16-bit write path.

## Interface
Parameters:
- `WAIT_MIN`, default 1: minimum strobe-low cycles per byte; legal range 1–15.
- `TIMEOUT`, default 255: maximum strobe-low cycles per byte before abort; legal range WAIT_MIN–255.

Ports:
- `sysClock` in 1: system clock; all state changes on the rising edge.
- `sysResetN` in 1: reset, asynchronous, active-low.
- `regAddr` in 16: access address, sampled at request acceptance.
- `memWData` in 16: write data, sampled at acceptance; low byte is written to addr, high byte to addr+1.
- `memRead` in 1: read request, level-sampled in IDLE.
- `memWrite` in 1: write request, level-sampled in IDLE.
- `memWord` in 1: 1 = 16-bit access, 0 = byte access; sampled at acceptance.
- `busRead` in 1: when 1, drive the captured low read byte onto `intD`.
- `intD` inout 8: internal data bus; high-Z whenever `busRead` is 0.
- `highOut` out 8: high byte of the last 16-bit read.
- `memBusy` out 1: access in progress.
- `memDone` out 1: one-cycle completion pulse.
- `memErr` out 1: timeout flag; sticky until the next accepted request.
- `extA` out 16: external address.
- `extD` inout 8: external data; driven only during write SETUP, STROBE and HOLD.
- `extRdN` out 1: read strobe, active-low.
- `extWrN` out 1: write strobe, active-low.
- `extReady` in 1: device ready, sampled while strobe is low.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- **IDLE**
  - If `memRead` or `memWrite` is 1, accept the request: latch address, direction, word flag and write data; clear `memErr`; set `memBusy`; go to SETUP.
  - If both are 1, the access is treated as a read.
  - Requests arriving while busy are ignored and are not queued.
- **SETUP** (1 cycle)
  - `extA` shows the current byte address; strobes are high.
  - Writes drive `extD` with the current byte.
- **STROBE**
  - The selected strobe is low; `waitCnt` increments each cycle.
  - Exit to HOLD when `waitCnt`≥WAIT_MIN and `extReady`=1. On a read, `extD` is captured into the low or high byte register on that edge.
  - If `waitCnt` reaches TIMEOUT without exit: set `memErr`, go to HOLD and mark the access finished (any remaining byte is skipped).
- **HOLD** (1 cycle)
  - Strobes are high; address and write data are held.
  - If this is the first byte of a word and there was no timeout: address←address+1, go to SETUP. The address wraps 16'hFFFF→16'h0000.
  - Otherwise: pulse `memDone`, clear `memBusy`, go to IDLE.
- Read capture routing:
  - Byte read: the captured byte goes to the low register; `highOut` is unchanged.
  - Word read: the first byte goes to the low register, the second byte to `highOut`.
- Reset values: state IDLE, `extA`=16'h0000, `extRdN`=`extWrN`=1, `extD` Z, `intD` Z, `memBusy`=`memDone`=`memErr`=0, `highOut`=8'h00, low read register=8'h00.
- Reset asserted mid-access: strobes go high and buses release immediately (asynchronous); there is no `memDone`.

## Timing
- Request sampled at edge 0.
  - SETUP occupies cycle 1.
  - STROBE occupies cycles 2 to 1+N, where N = max(WAIT_MIN, cycles until `extReady`).
  - HOLD follows.
- Byte access, WAIT_MIN=1, ready tied high: `memDone` high in cycle 3; 3-cycle latency.
- Word access: 6 cycles minimum; `memDone` only in the final HOLD.
- A new request can be accepted on the edge ending the cycle after `memDone`, since IDLE lasts at least 1 cycle.
- Captured read data is valid on `intD` (when `busRead`=1) and on `highOut` from the `memDone` cycle onward, and holds until the next read capture.
- `memErr` is valid together with `memDone`.
- All outputs are registered, except `intD` and `extD`, which are combinational tri-state enables.

## Structure
- Shared package `r88_pkg`: state encoding constants (IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, HOLD=2'd3) and the default WAIT_MIN and TIMEOUT values.
- Single module; no sub-module is needed. `waitCnt` is 8 bits wide.

## Test plan
- Byte read, WAIT_MIN=1, `regAddr`=16'h1234, device returns 8'hA5, ready high → `extA`=1234 and `extRdN` low for 1 cycle; `memDone` in cycle 3; `intD`=8'hA5 with `busRead`=1.
- Word write, `regAddr`=16'hFFFF, `memWData`=16'hBEEF → write 8'hEF to FFFF, then 8'hBE to 0000 (wrap); two `extWrN` pulses; one `memDone`.
- Word read with `extReady` held low 4 cycles on the second byte → second strobe lasts 5 cycles; `highOut` equals the second byte; total latency 10 cycles.
- `extReady` stuck low, TIMEOUT=8, word read → `memErr`=1 with `memDone` after 8 strobe cycles; second byte not attempted; `memErr` clears on the next accepted request.
- `memRead` and `memWrite` both asserted together → read cycle; `extWrN` stays high; a request re-asserted while `memBusy` is ignored.
- `sysResetN` asserted during STROBE → `extRdN`/`extWrN` go high and `extD` goes Z without waiting for a clock; no `memDone`; after release, state is IDLE with all reset values.
